sc_link_monitor: RTL and testbench

//  Consumer side of the LL/SC link. Holds the link set by LL (valid bit plus granule address).

---
 rtl/sc_link_monitor.sv | 116 +++++++++++
 tb/tb_sc_link_monitor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sc_link_monitor.sv
// LL/SC link monitor: holds the LL link, kills it on snoop, flush or timeout,
// and resolves each SC to pass/fail with a single stall cycle.
module sc_link_monitor #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned GRANULE_LSB  = 2,
   parameter int unsigned LINK_TIMEOUT = 256,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              ll_valid,
   input  logic [ADDR_W-1:0] ll_addr,
   input  logic              sc_req,
   input  logic [ADDR_W-1:0] sc_addr,
   input  logic              snoop_valid,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic              stallreq,
   output logic              sc_done,
   output logic              sc_pass,
   output logic              sc_mem_we,
   output logic              llbit_o,
   output logic [ADDR_W-1:0] link_addr
);

   localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << GRANULE_LSB) - ADDR_W'(1));
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LINK_TIMEOUT - 1);
   localparam bit                TIMEOUT_ON = (LINK_TIMEOUT != 0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LINKED  = 2'd1,
      RESOLVE = 2'd2
   } state_t;

   state_t             state;
   logic [ADDR_W-1:0]  link_q;
   logic [CNT_W-1:0]   cnt;
   logic               done_q;
   logic               pass_q;

   logic sc_match;
   logic snoop_hit;
   logic sc_accept;
   logic timeout_hit;

   // Granule compares done on the full address under a mask.
   assign sc_match    = ((sc_addr & ADDR_MASK) == link_q);
   assign snoop_hit   = snoop_valid && ((snoop_addr & ADDR_MASK) == link_q);
   assign sc_accept   = sc_req && !flush && (state != RESOLVE);
   assign timeout_hit = TIMEOUT_ON && (cnt == CNT_LAST);

   assign stallreq  = rst && sc_accept;
   assign llbit_o   = (state == LINKED);
   assign link_addr = link_q;

   // A flush arriving in RESOLVE squashes the pulse so the SC store never commits.
   assign sc_done   = done_q && !flush;
   assign sc_pass   = pass_q && !flush;
   assign sc_mem_we = done_q && pass_q && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         link_q <= '0;
         cnt    <= '0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         pass_q <= 1'b0;
         if (flush) begin
            state  <= IDLE;
            link_q <= '0;
            cnt    <= '0;
         end else begin
            case (state)
               IDLE, LINKED: begin
                  if (sc_req) begin
                     // Link is consumed whatever the outcome.
                     done_q <= 1'b1;
                     pass_q <= (state == LINKED) && sc_match && !snoop_hit;
                     state  <= RESOLVE;
                     cnt    <= '0;
                  end else if (ll_valid) begin
                     state  <= LINKED;
                     link_q <= ll_addr & ADDR_MASK;
                     cnt    <= '0;
                  end else if (state == LINKED) begin
                     if (snoop_hit || timeout_hit) begin
                        state <= IDLE;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
               end
               RESOLVE: begin
                  if (ll_valid) begin
                     state  <= LINKED;
                     link_q <= ll_addr & ADDR_MASK;
                     cnt    <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sc_link_monitor.sv
// Directed bench for sc_link_monitor; SC outcomes are queued when the SC is
// driven and compared when sc_done appears.
module tb_sc_link_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        ll_valid = 1'b0;
   logic [31:0] ll_addr = '0;
   logic        sc_req = 1'b0;
   logic [31:0] sc_addr = '0;
   logic        snoop_valid = 1'b0;
   logic [31:0] snoop_addr = '0;
   logic        stallreq;
   logic        sc_done;
   logic        sc_pass;
   logic        sc_mem_we;
   logic        llbit_o;
   logic [31:0] link_addr;

   int passed = 0;
   int total  = 0;
   bit exp_q[$];

   sc_link_monitor #(
      .ADDR_W(32), .GRANULE_LSB(2), .LINK_TIMEOUT(4), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .ll_valid(ll_valid), .ll_addr(ll_addr),
      .sc_req(sc_req), .sc_addr(sc_addr),
      .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
      .stallreq(stallreq), .sc_done(sc_done), .sc_pass(sc_pass),
      .sc_mem_we(sc_mem_we), .llbit_o(llbit_o), .link_addr(link_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ll(input string tag, input logic [31:0] a, input logic snp, input logic [31:0] sa);
      ll_valid = 1'b1; ll_addr = a; snoop_valid = snp; snoop_addr = sa;
      step();
      ll_valid = 1'b0; snoop_valid = 1'b0;
      chk({tag, "_llbit"}, 32'(llbit_o), 32'd1);
      chk({tag, "_link_addr"}, link_addr, a & 32'hFFFF_FFFC);
   endtask

   task automatic do_sc(input string tag, input logic [31:0] a, input logic snp,
                        input logic [31:0] sa, input logic lv, input logic [31:0] la,
                        input bit exp_pass);
      int waited;
      bit e;
      sc_req = 1'b1; sc_addr = a; snoop_valid = snp; snoop_addr = sa;
      ll_valid = lv; ll_addr = la;
      exp_q.push_back(exp_pass);
      #1;
      chk({tag, "_stall_on"}, 32'(stallreq), 32'd1);
      step();
      ll_valid = 1'b0; snoop_valid = 1'b0;
      #1;
      chk({tag, "_stall_off"}, 32'(stallreq), 32'd0);
      sc_req = 1'b0;
      waited = 1;
      while (!sc_done && waited < 4) begin
         step();
         waited++;
      end
      chk({tag, "_latency"}, 32'(waited), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      chk({tag, "_pass"}, 32'(sc_pass), 32'(e));
      chk({tag, "_mem_we"}, 32'(sc_mem_we), 32'(e));
      chk({tag, "_llbit_resolve"}, 32'(llbit_o), 32'd0);
      step();
      chk({tag, "_done_clear"}, 32'(sc_done), 32'd0);
      chk({tag, "_llbit_after"}, 32'(llbit_o), 32'd0);
   endtask

   initial begin
      step();
      chk("rst_llbit", 32'(llbit_o), 32'd0);
      chk("rst_link_addr", link_addr, 32'd0);
      chk("rst_done", 32'(sc_done), 32'd0);
      chk("rst_pass", 32'(sc_pass), 32'd0);
      chk("rst_mem_we", 32'(sc_mem_we), 32'd0);
      chk("rst_stall", 32'(stallreq), 32'd0);
      rst = 1'b1;
      step();

      // LL then SC three cycles later, landing on the timeout edge.
      do_ll("t1_ll", 32'h1000, 1'b0, 32'h0);
      repeat (3) step();
      chk("t1_llbit_held", 32'(llbit_o), 32'd1);
      do_sc("t1_sc", 32'h1000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

      // Snoop in another word keeps the link; same word kills it.
      do_ll("t2_ll", 32'h1000, 1'b0, 32'h0);
      snoop_valid = 1'b1; snoop_addr = 32'h1004;
      step();
      chk("t2_snoop_other", 32'(llbit_o), 32'd1);
      snoop_addr = 32'h1002;
      step();
      snoop_valid = 1'b0;
      chk("t2_snoop_kill", 32'(llbit_o), 32'd0);
      do_sc("t2_sc", 32'h1000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Wrong address fails and consumes the link.
      do_ll("t3_ll", 32'h1000, 1'b0, 32'h0);
      do_sc("t3_sc_wrong", 32'h1004, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      do_sc("t3_sc_again", 32'h1000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Same-cycle snoop fails the SC; same-cycle snoop loses to LL.
      do_ll("t4_ll", 32'h1000, 1'b0, 32'h0);
      do_sc("t4_sc_snoop", 32'h1000, 1'b1, 32'h1001, 1'b0, 32'h0, 1'b0);
      do_ll("t4_ll_snoop", 32'h2000, 1'b1, 32'h2000);
      do_sc("t4_sc_with_ll", 32'h2003, 1'b0, 32'h0, 1'b1, 32'h3000, 1'b1);
      do_sc("t4_sc_idle", 32'h3000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Timeout of 4: link still up after 3 idle edges, gone on the 4th.
      do_ll("t5_ll", 32'h3000, 1'b0, 32'h0);
      repeat (3) step();
      chk("t5_llbit_3", 32'(llbit_o), 32'd1);
      step();
      chk("t5_llbit_4", 32'(llbit_o), 32'd0);
      do_sc("t5_sc", 32'h3000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Flush during RESOLVE squashes the pulse.
      do_ll("t6_ll", 32'h1000, 1'b0, 32'h0);
      sc_req = 1'b1; sc_addr = 32'h1000;
      step();
      sc_req = 1'b0; flush = 1'b1;
      #1;
      chk("t6_flush_done", 32'(sc_done), 32'd0);
      chk("t6_flush_we", 32'(sc_mem_we), 32'd0);
      step();
      flush = 1'b0;
      chk("t6_flush_done_after", 32'(sc_done), 32'd0);
      chk("t6_flush_llbit", 32'(llbit_o), 32'd0);

      // Async reset mid-LINKED with an SC pending.
      do_ll("t7_ll", 32'h4000, 1'b0, 32'h0);
      sc_req = 1'b1; sc_addr = 32'h4000;
      #1;
      chk("t7_stall_pre", 32'(stallreq), 32'd1);
      rst = 1'b0;
      #1;
      chk("t7_rst_llbit", 32'(llbit_o), 32'd0);
      chk("t7_rst_link_addr", link_addr, 32'd0);
      chk("t7_rst_stall", 32'(stallreq), 32'd0);
      sc_req = 1'b0;
      step();
      rst = 1'b1;
      step();

      // Async reset mid-RESOLVE drops the pulse at once.
      do_ll("t8_ll", 32'h5000, 1'b0, 32'h0);
      sc_req = 1'b1; sc_addr = 32'h5000;
      step();
      sc_req = 1'b0;
      chk("t8_done_pre", 32'(sc_done), 32'd1);
      rst = 1'b0;
      #1;
      chk("t8_rst_done", 32'(sc_done), 32'd0);
      chk("t8_rst_we", 32'(sc_mem_we), 32'd0);
      step();
      rst = 1'b1;
      step();
      chk("t8_idle_done", 32'(sc_done), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
